cpu_mem_port: RTL

- Parametrised synchronous memory responder for the 6502 core. Replaces the flat combinational ROM array with a single-port RAM/ROM.
- Adds a configurable write-protected ROM window, address mirroring and programmable wait states.
- Drives a ready line back to the core so the core stalls until data is valid.
- Sits between cpu_core's addr/din bus and on-chip block RAM.

---
 rtl/cpu_mem_port.sv | 106 ++++++++++
 1 files changed

// File: rtl/cpu_mem_port.sv
// Synchronous memory responder for the 6502 core: single-port RAM with a
// write-protected ROM window, address mirroring and programmable wait states.
//
// state  | meaning
// S_IDLE | waiting for req; request fields latched on the accepting edge
// S_WAIT | inserting WAIT_STATES cycles; counter runs down to terminal count
// S_DONE | access completes; ready pulses, write commits or is rejected
module cpu_mem_port #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH_LOG2  = 15,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 16'h8000,
  parameter int                WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              wp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  logic                  accept;
  logic                  rom_hit;
  logic                  rd_we;
  logic                  load_rd;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign accept  = (state_q == S_IDLE) && req;
  assign rom_hit = (addr_q >= ROM_BASE);
  assign wr_idx  = addr_q[DEPTH_LOG2-1:0];

  // With no wait states the read happens on the accepting edge itself, so the
  // index and direction come straight from the bus rather than the latches.
  assign rd_idx  = accept ? addr[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];
  assign rd_we   = accept ? we : we_q;
  assign load_rd = (state_d == S_DONE) && (state_q != S_DONE) && !rd_we;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = HAS_WAIT ? S_WAIT : S_DONE;
      S_WAIT: if (cnt_q <= 4'd1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches, wait counter and read-data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        cnt_q   <= WS_LOAD;
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (load_rd) rdata_q <= mem[rd_idx];
    end
  end

  // Write commit at the end of DONE; an async reset before that edge aborts it
  always_ff @(posedge clk) begin
    if (state_q == S_DONE && we_q && !rom_hit) mem[wr_idx] <= wdata_q;
  end

  assign rdata  = rdata_q;
  assign ready  = (state_q == S_DONE);
  assign wp_err = ready && we_q && rom_hit;
  assign busy   = (state_q != S_IDLE);

endmodule
